// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared control-field layout and safe reset constants for pipeline stage buffers
package pipe_pkg;

    // ID/EX control layout: RegWrite, MemToReg, MemWrite, MemRead, Branch, AluSrc, RegDst, AluOp[1:0]
    localparam int IDEX_CTRL_W  = 9;

    // EX/MEM control layout
    localparam int EXMEM_REGW     = 0;
    localparam int EXMEM_MEMTOREG = 1;
    localparam int EXMEM_MEMW     = 2;
    localparam int EXMEM_MEMR     = 3;
    localparam int EXMEM_BRANCH   = 4;
    localparam int EXMEM_ZERO     = 5;
    localparam int EXMEM_RD_LSB   = 6;
    localparam int EXMEM_RD_MSB   = 10;
    localparam int EXMEM_CTRL_W   = 11;

    // MEM/WB control layout: RegWrite, MemToReg, rd[4:0]
    localparam int MEMWB_CTRL_W = 7;

    // All-zero decodes as no register write, no memory access, no branch
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_RST  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_RST = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_RST = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - single ctrl+data holding register with valid, used as the stage skid slot
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of the slot valid
//   loadEn              capture ctrlIn/dataIn and mark the slot full
//   unloadEn            slot contents consumed, mark the slot empty
//   ctrlIn, dataIn      beat to capture
//   slotValid           slot holds a beat (registered)
//   slotCtrl, slotData  held beat
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = EXMEM_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_RST = EXMEM_CTRL_RST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              loadEn,
    input  logic              unloadEn,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              slotValid,
    output logic [CTRL_W-1:0] slotCtrl,
    output logic [DATA_W-1:0] slotData
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotValid <= 1'b0;
            slotCtrl  <= CTRL_RST;
            slotData  <= '0;
        end else if (flush) begin
            slotValid <= 1'b0;
            slotCtrl  <= CTRL_RST;
        end else if (loadEn) begin
            slotValid <= 1'b1;
            slotCtrl  <= ctrlIn;
            slotData  <= dataIn;
        end else if (unloadEn) begin
            slotValid <= 1'b0;
            slotCtrl  <= CTRL_RST;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline-stage buffer with flush, stall hold and optional skid slot
//
// Build option: PIPE_STAGE_SKID_EN adds a skid slot (capacity 2, registered in_ready).
// Without it the stage is a single register with in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   flush                          synchronous discard of held and incoming beats
//   in_valid/in_ready              upstream handshake
//   in_ctrl, in_data               upstream beat
//   out_valid/out_ready            downstream handshake
//   out_ctrl, out_data             held beat; out_ctrl is CTRL_RST whenever empty
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = EXMEM_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_RST = EXMEM_CTRL_RST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              mValid;
    logic [CTRL_W-1:0] mCtrl;
    logic [DATA_W-1:0] mData;

    logic              sValid;
    logic [CTRL_W-1:0] sCtrl;
    logic [DATA_W-1:0] sData;

    logic              inReady;
    logic              inXfer;
    logic              mFree;

    // M can take a new beat when empty or when its beat leaves this cycle
    assign mFree  = ~mValid | out_ready;
    assign inXfer = in_valid & inReady;

`ifdef PIPE_STAGE_SKID_EN
    logic skidLoad;
    logic skidUnload;

    // Ready depends only on registered state, so out_ready never reaches in_ready
    assign inReady    = ~sValid;
    // While S is full inReady is 0, so S only loads when M is full and stalled
    assign skidLoad   = inXfer & ~mFree;
    assign skidUnload = mFree & sValid;

    pipe_skid_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .loadEn    (skidLoad),
        .unloadEn  (skidUnload),
        .ctrlIn    (in_ctrl),
        .dataIn    (in_data),
        .slotValid (sValid),
        .slotCtrl  (sCtrl),
        .slotData  (sData)
    );
`else
    assign inReady = mFree;
    assign sValid  = 1'b0;
    assign sCtrl   = CTRL_RST;
    assign sData   = '0;
`endif

    // Main register. The empty-state control value is stored, not muxed,
    // so out_ctrl comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid <= 1'b0;
            mCtrl  <= CTRL_RST;
            mData  <= '0;
        end else if (flush) begin
            mValid <= 1'b0;
            mCtrl  <= CTRL_RST;
        end else if (mFree) begin
            if (sValid) begin
                // Older beat in S goes first to keep order
                mValid <= 1'b1;
                mCtrl  <= sCtrl;
                mData  <= sData;
            end else if (inXfer) begin
                mValid <= 1'b1;
                mCtrl  <= in_ctrl;
                mData  <= in_data;
            end else begin
                mValid <= 1'b0;
                mCtrl  <= CTRL_RST;
            end
        end
    end

    assign in_ready  = inReady;
    assign out_valid = mValid;
    assign out_ctrl  = mCtrl;
    assign out_data  = mData;

endmodule
